// File: rtl/score_tracker_if.sv
// Signal bundle between score_tracker, the game physics block and the display blocks.
interface score_tracker_if;
  logic        tick;
  logic        start;
  logic [9:0]  bird_y;
  logic [8:0]  p1_x;
  logic [8:0]  p2_x;
  logic [8:0]  p1_gap;
  logic [8:0]  p2_gap;
  logic [1:0]  game_state;
  logic        lost;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        pass_pulse;

  modport master (
    output tick, start, bird_y, p1_x, p2_x, p1_gap, p2_gap,
    input  game_state, lost, score_bcd, high_bcd, pass_pulse
  );

  modport slave (
    input  tick, start, bird_y, p1_x, p2_x, p1_gap, p2_gap,
    output game_state, lost, score_bcd, high_bcd, pass_pulse
  );
endinterface

// File: rtl/score_tracker.sv
// Game rules: collision/pass detection, IDLE/PLAY/LOST FSM, saturating BCD score.
// Define HIGH_SCORE_EN to build the high-score register; otherwise high_bcd is tied to 0.
module score_tracker #(
  parameter int unsigned BIRD_X   = 160,
  parameter int unsigned BIRD_W   = 16,
  parameter int unsigned BIRD_H   = 16,
  parameter int unsigned PILLAR_W = 40,
  parameter int unsigned GAP_H    = 120,
  parameter int unsigned SCREEN_H = 480
) (
  input logic            clk,
  input logic            clr,
  score_tracker_if.slave bus
);

  localparam int unsigned AW = 11;
  localparam int unsigned SW = 16;

  typedef logic [AW-1:0] sum_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, LOST = 2'd2} state_t;

  state_t        state;
  logic          start_q;
  logic          passed1;
  logic          passed2;
  logic          lost;
  logic          pass_pulse;
  logic [SW-1:0] score_bcd;

  function automatic logic pass_cond(input logic [8:0] px);
    return (sum_t'(px) + sum_t'(PILLAR_W)) <= sum_t'(BIRD_X);
  endfunction

  // Pillar has wrapped back to the right of the bird and may score again.
  function automatic logic wrapped(input logic [8:0] px);
    return sum_t'(px) > sum_t'(BIRD_X + BIRD_W);
  endfunction

  function automatic logic pillar_hit(input logic [8:0] px, input logic [8:0] pgap,
                                      input logic [9:0] by);
    logic x_ovl;
    logic out_gap;
    x_ovl   = (sum_t'(px) <= sum_t'(BIRD_X + BIRD_W - 1)) &&
              ((sum_t'(px) + sum_t'(PILLAR_W - 1)) >= sum_t'(BIRD_X));
    out_gap = (sum_t'(by) < sum_t'(pgap)) ||
              ((sum_t'(by) + sum_t'(BIRD_H)) > (sum_t'(pgap) + sum_t'(GAP_H)));
    return x_ovl && out_gap;
  endfunction

  // Add 0..2 to a 4-digit BCD value; a carry out of the top digit pins it at 9999.
  function automatic logic [SW-1:0] bcd_add_sat(input logic [SW-1:0] v, input logic [1:0] n);
    logic [SW-1:0] r;
    logic [4:0]    d;
    logic [4:0]    c;
    r = v;
    c = 5'(n);
    for (int i = 0; i < 4; i++) begin
      d = 5'(v[i*4 +: 4]) + c;
      if (d > 5'd9) begin
        r[i*4 +: 4] = 4'(d - 5'd10);
        c           = 5'd1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c           = 5'd0;
      end
    end
    if (c != 5'd0) r = 16'h9999;
    return r;
  endfunction

  logic       start_rise_c;
  logic       p1_pass_c;
  logic       p2_pass_c;
  logic       hit_c;
  logic [1:0] n_pass_c;

  assign start_rise_c = bus.start & ~start_q;
  assign p1_pass_c    = pass_cond(bus.p1_x) & ~passed1;
  assign p2_pass_c    = pass_cond(bus.p2_x) & ~passed2;
  assign n_pass_c     = 2'(p1_pass_c) + 2'(p2_pass_c);
  assign hit_c        = ((sum_t'(bus.bird_y) + sum_t'(BIRD_H)) > sum_t'(SCREEN_H)) ||
                        pillar_hit(bus.p1_x, bus.p1_gap, bus.bird_y) ||
                        pillar_hit(bus.p2_x, bus.p2_gap, bus.bird_y);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      passed1    <= 1'b0;
      passed2    <= 1'b0;
      lost       <= 1'b0;
      pass_pulse <= 1'b0;
      score_bcd  <= '0;
    end else begin
      start_q    <= bus.start;
      pass_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise_c) begin
            state     <= PLAY;
            score_bcd <= '0;
            // Pillars already behind the bird at launch must not score.
            passed1   <= pass_cond(bus.p1_x);
            passed2   <= pass_cond(bus.p2_x);
          end
        end
        PLAY: begin
          if (bus.tick) begin
            if (p1_pass_c)              passed1 <= 1'b1;
            else if (wrapped(bus.p1_x)) passed1 <= 1'b0;
            if (p2_pass_c)              passed2 <= 1'b1;
            else if (wrapped(bus.p2_x)) passed2 <= 1'b0;
            if (hit_c) begin
              state <= LOST;
              lost  <= 1'b1;
            end else if (n_pass_c != 2'd0) begin
              score_bcd  <= bcd_add_sat(score_bcd, n_pass_c);
              pass_pulse <= 1'b1;
            end
          end
        end
        LOST: begin
          if (start_rise_c) begin
            state <= IDLE;
            lost  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          lost  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SW-1:0] high_bcd;
  logic          high_chk;

  // high_chk marks the first cycle in LOST; packed BCD orders like binary.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      high_bcd <= '0;
      high_chk <= 1'b0;
    end else begin
      high_chk <= (state == PLAY) && bus.tick && hit_c;
      if (high_chk && (score_bcd > high_bcd)) high_bcd <= score_bcd;
    end
  end

  assign bus.high_bcd = high_bcd;
`else
  assign bus.high_bcd = 16'h0000;
`endif

  assign bus.game_state = state;
  assign bus.lost       = lost;
  assign bus.score_bcd  = score_bcd;
  assign bus.pass_pulse = pass_pulse;

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: integer reference model checked every cycle, directed and random play.
module tb_score_tracker;

  localparam int BX = 160;
  localparam int BW = 16;
  localparam int BH = 16;
  localparam int PW = 40;
  localparam int GH = 120;
  localparam int SH = 480;

  logic clk;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  score_tracker_if bus ();

  score_tracker dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: game state 0/1/2, score and high score held as plain integers.
  int m_state  = 0;
  int m_score  = 0;
  int m_high   = 0;
  bit m_passed [2] = '{0, 0};
  bit m_start_q = 0;
  bit m_pulse   = 0;
  bit m_first   = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [15:0] exp_high();
`ifdef HIGH_SCORE_EN
    return to_bcd(m_high);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_step();
    int px [2];
    int pg [2];
    int by;
    int n;
    bit sr;
    bit any_hit;
    px[0] = int'(bus.p1_x);   px[1] = int'(bus.p2_x);
    pg[0] = int'(bus.p1_gap); pg[1] = int'(bus.p2_gap);
    by    = int'(bus.bird_y);
    sr        = bus.start && !m_start_q;
    m_start_q = bus.start;
    m_pulse   = 0;
    if (m_first && m_score > m_high) m_high = m_score;
    m_first = 0;
    case (m_state)
      0: if (sr) begin
        m_state = 1;
        m_score = 0;
        for (int i = 0; i < 2; i++) m_passed[i] = (px[i] + PW <= BX);
      end
      1: if (bus.tick) begin
        any_hit = (by + BH > SH);
        n = 0;
        for (int i = 0; i < 2; i++) begin
          if (px[i] <= BX + BW - 1 && px[i] + PW - 1 >= BX && (by < pg[i] || by + BH > pg[i] + GH))
            any_hit = 1;
          if (px[i] + PW <= BX && !m_passed[i]) begin
            n++;
            m_passed[i] = 1;
          end else if (px[i] > BX + BW) begin
            m_passed[i] = 0;
          end
        end
        if (any_hit) begin
          m_state = 2;
          m_first = 1;
        end else if (n > 0) begin
          m_score = (m_score + n > 9999) ? 9999 : m_score + n;
          m_pulse = 1;
        end
      end
      2: if (sr) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_state = 0; m_score = 0; m_high = 0;
      m_passed[0] = 0; m_passed[1] = 0;
      m_start_q = 0; m_pulse = 0; m_first = 0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("game_state", 16'(bus.game_state), 16'(m_state));
    chk("lost",       16'(bus.lost),       16'(m_state == 2));
    chk("score_bcd",  bus.score_bcd,       to_bcd(m_score));
    chk("high_bcd",   bus.high_bcd,        exp_high());
    chk("pass_pulse", 16'(bus.pass_pulse), 16'(m_pulse));
  end

  task automatic do_tick(input int by, input int p1x, input int p1g, input int p2x, input int p2g);
    @(negedge clk);
    bus.bird_y = 10'(by);
    bus.p1_x   = 9'(p1x);  bus.p1_gap = 9'(p1g);
    bus.p2_x   = 9'(p2x);  bus.p2_gap = 9'(p2g);
    bus.tick   = 1'b1;
    @(negedge clk);
    bus.tick   = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic double_pass();
    do_tick(250, 200, 200, 200, 200);
    do_tick(250, 120, 200, 120, 200);
  endtask

  task automatic single_pass();
    do_tick(250, 200, 200, 400, 200);
    do_tick(250, 120, 200, 400, 200);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 16'(bus.game_state), 16'h0);
    chk({tag, "_lost"},  16'(bus.lost),       16'h0);
    chk({tag, "_score"}, bus.score_bcd,       16'h0);
    chk({tag, "_high"},  bus.high_bcd,        16'h0);
    chk({tag, "_pulse"}, 16'(bus.pass_pulse), 16'h0);
  endtask

  initial begin
    clr = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0;
    bus.bird_y = 10'd250;
    bus.p1_x = 9'd150; bus.p1_gap = 9'd200;
    bus.p2_x = 9'd400; bus.p2_gap = 9'd200;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;

    // Held button gives one IDLE->PLAY transition.
    press_start();
    chk("start_play", 16'(bus.game_state), 16'h1);

    // Single pass on p1_x = 120.
    for (int x = 150; x >= 119; x--) begin
      do_tick(250, x, 200, 400, 200);
      if (x == 120) begin
        chk("pass_score", bus.score_bcd, 16'h0001);
        chk("pass_pulse_lit", 16'(bus.pass_pulse), 16'h1);
      end
    end
    chk("no_repeat_pass", bus.score_bcd, 16'h0001);

    // Carry into the hundreds digit.
    repeat (49) double_pass();
    chk("score_99", bus.score_bcd, 16'h0099);
    single_pass();
    chk("carry_100", bus.score_bcd, 16'h0100);

    // Saturation at 9999.
    repeat (4949) double_pass();
    chk("score_9998", bus.score_bcd, 16'h9998);
    single_pass();
    chk("score_9999", bus.score_bcd, 16'h9999);
    double_pass();
    chk("sat_score", bus.score_bcd, 16'h9999);
    chk("sat_pulse", 16'(bus.pass_pulse), 16'h1);

    // Double pass with floor hit: LOST, score unchanged.
    do_tick(250, 200, 200, 200, 200);
    do_tick(470, 120, 200, 120, 200);
    chk("floor_state", 16'(bus.game_state), 16'h2);
    chk("floor_lost", 16'(bus.lost), 16'h1);
    chk("floor_score", bus.score_bcd, 16'h9999);
    chk("high_before", bus.high_bcd, 16'h0000);
    @(negedge clk);
`ifdef HIGH_SCORE_EN
    chk("high_after", bus.high_bcd, 16'h9999);
`else
    chk("high_after", bus.high_bcd, 16'h0000);
`endif

    // Pillar hit with a lower score leaves the high score alone.
    press_start();
    chk("back_idle", 16'(bus.game_state), 16'h0);
    press_start();
    chk("replay_score", bus.score_bcd, 16'h0000);
    do_tick(100, 150, 200, 400, 200);
    chk("pillar_state", 16'(bus.game_state), 16'h2);
    chk("pillar_lost", 16'(bus.lost), 16'h1);
    repeat (2) @(negedge clk);
`ifdef HIGH_SCORE_EN
    chk("high_kept", bus.high_bcd, 16'h9999);
`else
    chk("high_kept", bus.high_bcd, 16'h0000);
`endif

    // Reset mid-PLAY with score 0042.
    press_start();
    press_start();
    repeat (21) double_pass();
    chk("score_42", bus.score_bcd, 16'h0042);
    @(negedge clk);
    #2 clr = 1'b1;
    #1 chk_all_zero("midclr");
    @(negedge clk);
    #2 clr = 1'b0;

    // Random play against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.start  = ($urandom_range(0, 5) == 0);
      bus.tick   = 1'($urandom_range(0, 1));
      bus.p1_gap = 9'($urandom_range(60, 360));
      bus.p2_gap = 9'($urandom_range(60, 360));
      bus.p1_x   = 9'($urandom_range(0, 511));
      bus.p2_x   = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) bus.bird_y = 10'($urandom_range(0, 479));
      else                           bus.bird_y = 10'(int'(bus.p1_gap) + $urandom_range(0, 104));
    end
    @(negedge clk);
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
